// File: rtl/mem_access_unit.sv
// Load/store sequencer between a multicycle RISC-V datapath and a word-wide memory
// without byte enables: sub-word stores are done as read-modify-write.
module mem_access_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oMisaligned,
  output logic [31:0] oRData,
  output logic [31:0] oMemAdress,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [31:0] oMemWData,
  input  logic [31:0] iMemRData
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  function automatic logic is_reject(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic rej;
    case (f3)
      3'b000:  rej = 1'b0;
      3'b001:  rej = lane[0];
      3'b010:  rej = (lane != 2'b00);
      3'b100:  rej = we;
      3'b101:  rej = we | lane[0];
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else begin
      r[{lane[1], 4'b0000} +: 16] = wd;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] madr_q, madr_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic [31:0] mwd_q, mwd_d;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    madr_d   = madr_q;
    mwd_d    = mwd_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iReq) begin
          funct3_d = iFunct3;
          we_d     = iWe;
          lane_d   = iAddr[1:0];
          wdata_d  = iWData[15:0];
          madr_d   = {iAddr[31:10], iAddr[11:2]};
          if (is_reject(iWe, iFunct3, iAddr[1:0])) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else if (iWe && (iFunct3 == 3'b010)) begin
            state_d = S_WR;
            mwr_d   = 1'b1;
            mwd_d   = iWData;
          end else begin
            state_d = S_RD;
            mrd_d   = 1'b1;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_q == 2'd0) begin
          state_d = S_CAP;
        end else begin
          cnt_d = cnt_q - 2'd1;
          mrd_d = 1'b1;
        end
      end
      S_CAP: begin
        // Read word arrives this cycle: merge it for sub-word stores, extract it for loads.
        if (we_q) begin
          state_d = S_WR;
          mwr_d   = 1'b1;
          mwd_d   = store_merge(iMemRData, funct3_q, lane_q, wdata_q);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = load_extract(iMemRData, funct3_q, lane_q);
        end
      end
      S_WR: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      lane_q   <= 2'd0;
      wdata_q  <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      madr_q   <= 32'h0000_0000;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mwd_q    <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
      madr_q   <= madr_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      mwd_q    <= mwd_d;
    end
  end

  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oMisaligned = mis_q;
  assign oRData      = rdata_q;
  assign oMemAdress  = madr_q;
  assign oMemRead    = mrd_q;
  assign oMemWrite   = mwr_q;
  assign oMemWData   = mwd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) share stimulus, each
// with its own latency-accurate memory; results are compared to an arithmetic model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wd;
  logic        busy [2];
  logic        done [2];
  logic        mis  [2];
  logic        mrd  [2];
  logic        mwr  [2];
  logic [31:0] rdata  [2];
  logic [31:0] madr   [2];
  logic [31:0] mwd    [2];
  logic [31:0] mrdata [2];

  logic [31:0] mem [2][64];
  logic [31:0] ref_mem [64];
  int          age [2];
  logic        rd_prev [2];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic [31:0] word;
    bit          pulse;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LATENCY(1)) u_l1 (
    .iCLK(clk), .iRST(rst), .iReq(req), .iWe(we), .iFunct3(f3), .iAddr(addr), .iWData(wd),
    .oBusy(busy[0]), .oDone(done[0]), .oMisaligned(mis[0]), .oRData(rdata[0]),
    .oMemAdress(madr[0]), .oMemRead(mrd[0]), .oMemWrite(mwr[0]), .oMemWData(mwd[0]),
    .iMemRData(mrdata[0])
  );

  mem_access_unit #(.READ_LATENCY(3)) u_l3 (
    .iCLK(clk), .iRST(rst), .iReq(req), .iWe(we), .iFunct3(f3), .iAddr(addr), .iWData(wd),
    .oBusy(busy[1]), .oDone(done[1]), .oMisaligned(mis[1]), .oRData(rdata[1]),
    .oMemAdress(madr[1]), .oMemRead(mrd[1]), .oMemWrite(mwr[1]), .oMemWData(mwd[1]),
    .iMemRData(mrdata[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (L=%0d): got %h, expected %h", name, lat(k), act, exp);
    end
  endtask

  // Reference semantics of one access, from the width/alignment rules.
  function automatic void model(input logic m_we, input logic [2:0] m_f3, input logic [31:0] m_addr,
                                input logic [31:0] m_wd, input logic [31:0] old,
                                output logic [31:0] m_rd, output logic m_mis, output logic [31:0] m_word);
    int unsigned off;
    logic [31:0] b, h;
    off = m_addr % 4;
    b = (old >> (8 * off)) & 32'hFF;
    h = (old >> (16 * (off / 2))) & 32'hFFFF;
    m_mis = (m_f3 == 3 || m_f3 == 6 || m_f3 == 7) || (m_we && (m_f3 == 4 || m_f3 == 5)) ||
            ((m_f3 == 1 || m_f3 == 5) && (off % 2 != 0)) || (m_f3 == 2 && off != 0);
    m_rd = 32'h0;
    m_word = old;
    if (!m_mis && !m_we) begin
      case (m_f3)
        3'd0:    m_rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd1:    m_rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd4:    m_rd = b;
        3'd5:    m_rd = h;
        default: m_rd = old;
      endcase
    end
    if (!m_mis && m_we) begin
      case (m_f3)
        3'd0:    m_word = (old & ~(32'hFF << (8 * off))) | ((m_wd & 32'hFF) << (8 * off));
        3'd1:    m_word = (old & ~(32'hFFFF << (16 * (off / 2)))) | ((m_wd & 32'hFFFF) << (16 * (off / 2)));
        default: m_word = m_wd;
      endcase
    end
  endfunction

  // One clock; then the memories act on what the DUTs present in the new cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        age[k] = 0;
        rd_prev[k] = 1'b0;
      end else begin
        if (mwr[k]) mem[k][madr[k][5:0]] = mwd[k];
        if (mrd[k] && !rd_prev[k]) age[k] = 1;
        else if (age[k] != 0 && age[k] < 8) age[k]++;
        rd_prev[k] = mrd[k];
      end
      mrdata[k] = (age[k] == lat(k) + 1) ? mem[k][madr[k][5:0]] : 32'h5A5A5A5A;
    end
  endtask

  task automatic chk_idle(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_ctrl"}, k, {27'h0, busy[k], done[k], mis[k], mrd[k], mwr[k]}, 32'h0);
      chk({name, "_rdata"}, k, rdata[k], 32'h0);
      chk({name, "_madr"}, k, madr[k], 32'h0);
      chk({name, "_mwdata"}, k, mwd[k], 32'h0);
    end
  endtask

  task automatic run_req(input logic t_we, input logic [2:0] t_f3, input logic [31:0] t_addr,
                         input logic [31:0] t_wd, input logic [31:0] exp_rd, input logic exp_mis,
                         input logic [31:0] exp_word, input bit pulse);
    int idx, exp_dc, n_reads, n_writes;
    int n_busy [2], n_rd [2], n_wr [2], n_done [2], n_both [2], n_adr [2], done_c [2];
    logic [31:0] seen_wd [2], seen_rd [2], rd_exp, word_exp, exp_madr;
    logic seen_mis [2];
    idx = int'(t_addr[7:2]);
    exp_madr = ((t_addr >> 10) << 10) | ((t_addr >> 2) & 32'h3FF);
    rd_exp = (!exp_mis && !t_we) ? exp_rd : last_rd;
    word_exp = (!exp_mis && t_we) ? exp_word : ref_mem[idx];
    for (int k = 0; k < 2; k++) begin
      n_busy[k] = 0; n_rd[k] = 0; n_wr[k] = 0; n_done[k] = 0; n_both[k] = 0; n_adr[k] = 0;
      done_c[k] = 0; seen_wd[k] = 32'h0; seen_rd[k] = 32'h0; seen_mis[k] = 1'b0;
    end
    req = 1'b1; we = t_we; f3 = t_f3; addr = t_addr; wd = t_wd;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        req = pulse;
        we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
      end else begin
        req = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) begin
          n_busy[k]++;
          if (madr[k] !== exp_madr) n_adr[k]++;
        end
        if (mrd[k]) n_rd[k]++;
        if (mwr[k]) begin n_wr[k]++; seen_wd[k] = mwd[k]; end
        if (mrd[k] && mwr[k]) n_both[k]++;
        if (done[k]) begin n_done[k]++; done_c[k] = c; seen_rd[k] = rdata[k]; seen_mis[k] = mis[k]; end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (exp_mis) exp_dc = 1;
      else if (t_we && t_f3 == 3'd2) exp_dc = 2;
      else if (t_we) exp_dc = lat(k) + 3;
      else exp_dc = lat(k) + 2;
      n_reads = (exp_mis || (t_we && t_f3 == 3'd2)) ? 0 : lat(k);
      n_writes = (!exp_mis && t_we) ? 1 : 0;
      chk("done_count", k, n_done[k], 1);
      chk("done_cycle", k, done_c[k], exp_dc);
      chk("busy_cycles", k, n_busy[k], exp_dc);
      chk("read_cycles", k, n_rd[k], n_reads);
      chk("write_cycles", k, n_wr[k], n_writes);
      chk("rd_wr_overlap", k, n_both[k], 0);
      chk("mem_addr_bad", k, n_adr[k], 0);
      chk("misaligned", k, {31'h0, seen_mis[k]}, {31'h0, exp_mis});
      chk("rdata_at_done", k, seen_rd[k], rd_exp);
      chk("rdata_hold", k, rdata[k], rd_exp);
      if (n_writes == 1) chk("write_data", k, seen_wd[k], word_exp);
      chk("mem_word", k, mem[k][idx], word_exp);
    end
    ref_mem[idx] = word_exp;
    last_rd = rd_exp;
  endtask

  initial begin
    logic [31:0] r_rd, r_word, r_addr, r_wd;
    logic r_mis, r_we;
    logic [2:0] r_f3;

    tbl[0]  = '{1'b0, 3'd2, 32'h10000004, 32'h0,        32'h8899AABB, 1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b0, 3'd0, 32'h10000005, 32'h0,        32'hFFFFFFAA, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 3'd4, 32'h10000005, 32'h0,        32'h000000AA, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 3'd1, 32'h10000006, 32'h0,        32'hFFFF8899, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 3'd5, 32'h10000006, 32'h0,        32'h00008899, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 3'd0, 32'h10000006, 32'hFFFFFF11, 32'h0,        1'b0, 32'h8811AABB, 1'b1};
    tbl[6]  = '{1'b0, 3'd2, 32'h10000004, 32'h0,        32'h8811AABB, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 3'd2, 32'h10000004, 32'h8899AABB, 32'h0,        1'b0, 32'h8899AABB, 1'b0};
    tbl[8]  = '{1'b1, 3'd1, 32'h10000004, 32'hABCD1234, 32'h0,        1'b0, 32'h88991234, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 32'h10000008, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    tbl[10] = '{1'b0, 3'd2, 32'h10000002, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 3'd1, 32'h10000001, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
    tbl[12] = '{1'b1, 3'd4, 32'h10000004, 32'h00000055, 32'h0,        1'b1, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 3'd3, 32'h10000004, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 3'd2, 32'h10000008, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        1'b0};

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem[0][i] = ref_mem[i];
      mem[1][i] = ref_mem[i];
    end
    ref_mem[1] = 32'h8899AABB;
    mem[0][1] = 32'h8899AABB;
    mem[1][1] = 32'h8899AABB;
    for (int k = 0; k < 2; k++) begin
      age[k] = 0; rd_prev[k] = 1'b0; mrdata[k] = 32'h5A5A5A5A;
    end
    last_rd = 32'h0;
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'h0; wd = 32'h0;
    @(negedge clk);
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++)
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].mis, tbl[i].word, tbl[i].pulse);

    // SB aborted by reset in the latency-1 instance's CAP cycle.
    req = 1'b1; we = 1'b1; f3 = 3'd0; addr = 32'h10000006; wd = 32'h00000011;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("abort");
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int k = 0; k < 2; k++) chk("abort_quiet", k, {30'h0, done[k], mwr[k]}, 32'h0);
    end
    for (int k = 0; k < 2; k++) chk("abort_mem", k, mem[k][1], 32'h88991234);
    last_rd = 32'h0;
    run_req(1'b0, 3'd2, 32'h10000004, 32'h0, 32'h88991234, 1'b0, 32'h0, 1'b0);

    // Reset and request together: the request is dropped.
    rst = 1'b1; req = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h10000004;
    tick();
    rst = 1'b0; req = 1'b0;
    tick();
    chk_idle("rst_req");
    last_rd = 32'h0;

    for (int i = 0; i < 60; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wd = $urandom;
      model(r_we, r_f3, r_addr, r_wd, ref_mem[r_addr[7:2]], r_rd, r_mis, r_word);
      run_req(r_we, r_f3, r_addr, r_wd, r_rd, r_mis, r_word, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Byte-lane load/store sequencer between the multicycle RISC-V datapath and the word-wide memory interface. It accepts one load or store request at a time and translates the byte address to the memory's word address. It extracts and sign- or zero-extends byte and halfword loads. Because memory has no byte enables, it performs SB/SH as read-modify-write.

## Interface
- READ_LATENCY, 1, cycles between first cycle of oMemRead and the cycle iMemRData is valid (legal 1..3)
- iCLK  in  1  clock, all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iReq  in  1  start access; sampled only in IDLE
- iWe  in  1  1 = store, 0 = load
- iFunct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- iAddr  in  32  byte address
- iWData  in  32  store data (low bits used for B/H)
- oBusy  out  1  high from accept until the DONE cycle inclusive
- oDone  out  1  one-cycle completion pulse
- oMisaligned  out  1  valid with oDone; access rejected
- oRData  out  32  extended load result; valid from DONE, held until next load completes
- oMemAdress  out  32  {addr[31:10], addr[11:2]}; bit 28 keeps the data/instruction select
- oMemRead  out  1  memory read enable
- oMemWrite  out  1  memory write enable, one cycle per store
- oMemWData  out  32  full word to write
- iMemRData  in  32  word read from memory

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE + iReq: latch iAddr, iWData, iFunct3, iWe. Assert oBusy.
- Reject cases go directly to DONE with oMisaligned=1 and no memory access:
  - funct3 011/110/111
  - store with funct3 100/101
  - H/HU with addr[0]=1
  - W with addr[1:0]≠00
- SW aligned: IDLE -> WR -> DONE.
- All loads, plus SB/SH: IDLE -> RD -> CAP.
  - RD lasts exactly READ_LATENCY cycles with oMemRead=1, using a down-counter.
  - CAP registers iMemRData into the word register with oMemRead=0.
  - After CAP, loads go to DONE; SB/SH go to WR.
- Merge (SB): lane = addr[1:0]; bits [8·lane+7 : 8·lane] = iWData[7:0], other bits keep the read word.
- Merge (SH): bits [16·addr[1]+15 : 16·addr[1]] = iWData[15:0].
- Extract: lane selection as for merge.
  - B sign-extends bit 7 of the lane; BU zero-extends.
  - H sign-extends bit 15 of the half; HU zero-extends.
  - W passes the word through.
- WR: oMemWrite=1 for exactly one cycle. oMemWData = merged word (SB/SH) or latched iWData (SW).
- DONE: oDone=1 for one cycle. oRData updates only for successful loads. Next state is IDLE.
- oMemAdress is constant from the accept edge through DONE. oMemRead and oMemWrite are never high together.
- iReq while oBusy=1 is ignored and not queued. A new request is accepted in the cycle after DONE.

## Timing
- Request sampled in cycle n (IDLE). L = READ_LATENCY.
- Load: RD in cycles n+1..n+L, CAP at n+L+1, oDone at n+L+2. For L=1 the load takes 3 cycles.
- SB/SH: CAP at n+L+1, WR at n+L+2, oDone at n+L+3.
- SW: WR at n+1, oDone at n+2.
- Reject: oDone and oMisaligned at n+1.
- Reset values: state IDLE; oBusy, oDone, oMisaligned, oMemRead, oMemWrite = 0; oRData, oMemAdress, oMemWData = 0; counter 0.
- Reset mid-operation (any state) returns to IDLE at that edge. A pending WR is never issued, and no oDone is produced for the aborted access.
- iRST and iReq asserted together: reset wins and the request is dropped.

## Test plan
- L=1: word at 0x10000004 holds 0x8899AABB; LW addr 0x10000004 -> oMemAdress 0x10000001, oMemRead high 1 cycle, oDone 3 cycles after accept, oRData 0x8899AABB.
- Same word: LB at 0x10000005 -> oRData 0xFFFFFFAA; LBU -> 0x000000AA; LH at 0x10000006 -> 0xFFFF8899; LHU -> 0x00008899.
- SB 0x11 at 0x10000006 -> one read, then a single write of 0x8811AABB; SH 0x1234 at 0x10000004 -> write 0x88991234. Check oMemRead and oMemWrite are never simultaneously high.
- SW 0xDEADBEEF at 0x10000008 -> no read, write at n+1, oDone at n+2. LW at 0x10000002, LH at 0x10000001, and SB with funct3 100 -> each gives oDone and oMisaligned at n+1 with no memory enables.
- READ_LATENCY=3: LW -> oMemRead high 3 cycles, oDone at n+5; iReq pulsed while busy is ignored.
- Assert iRST in the CAP cycle of an SB -> next cycle IDLE with all outputs 0, no oMemWrite, no oDone; a following LW completes normally.
